// File: rtl/rv_regfile_sched_pkg.sv
// Shared register-file definitions: register index width, the x0 index and data width.
// Ports: none (package only).
// Imported by the scheduler, its scoreboard and the interface.
package rv_defs;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_idx_t REG_X0 = '0;

  // x0 is hard-wired: it never owns a scoreboard bit and is never written.
  function automatic logic is_x0(input reg_idx_t idx);
    return (idx == REG_X0);
  endfunction

endpackage

// File: rtl/rv_regfile_sched_if.sv
// Bundle of decode, writeback, long-latency and register-file signals around the scheduler.
// slave: the scheduler side (consumes d_/w_/l_ inputs, drives stall/hold/ready/rf_*/status).
// master: the surrounding pipeline side (drives d_/w_/l_ inputs, observes the rest).
interface rv_regfile_sched_if;
  import rv_defs::*;

  // decode
  logic     d_valid_i;
  reg_idx_t d_rs1_i;
  reg_idx_t d_rs2_i;
  reg_idx_t d_rd_i;
  logic     d_use_rs1_i;
  logic     d_use_rs2_i;
  logic     d_long_i;
  logic     d_issue_i;
  logic     d_stall_o;
  // pipeline writeback
  reg_idx_t w_rd_i;
  data_t    w_rd_value_i;
  logic     w_rd_store_i;
  logic     w_hold_o;
  // long-latency results
  logic     l_valid_i;
  reg_idx_t l_rd_i;
  data_t    l_value_i;
  logic     l_ready_o;
  // register file write port
  reg_idx_t rf_rd_o;
  data_t    rf_rd_value_o;
  logic     rf_rd_store_o;
  // status
  logic     busy_o;
  logic     err_o;

  modport slave (
    input  d_valid_i, d_rs1_i, d_rs2_i, d_rd_i, d_use_rs1_i, d_use_rs2_i, d_long_i, d_issue_i,
    input  w_rd_i, w_rd_value_i, w_rd_store_i,
    input  l_valid_i, l_rd_i, l_value_i,
    output d_stall_o, w_hold_o, l_ready_o,
    output rf_rd_o, rf_rd_value_o, rf_rd_store_o,
    output busy_o, err_o
  );

  modport master (
    output d_valid_i, d_rs1_i, d_rs2_i, d_rd_i, d_use_rs1_i, d_use_rs2_i, d_long_i, d_issue_i,
    output w_rd_i, w_rd_value_i, w_rd_store_i,
    output l_valid_i, l_rd_i, l_value_i,
    input  d_stall_o, w_hold_o, l_ready_o,
    input  rf_rd_o, rf_rd_value_o, rf_rd_store_o,
    input  busy_o, err_o
  );

endinterface

// File: rtl/rv_regfile_sched_scoreboard.sv
// Pending-destination scoreboard for x1..x31: set on long issue, clear on result accept.
// Ports: clk_i/rst_i, one set port, one clear port, read ports for rs1/rs2/rd and the clearing rd.
// Reads are registered-state only; a set and a clear of the same register in one cycle leaves it set.
module rv_scoreboard
  import rv_defs::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     set_i,
  input  reg_idx_t set_rd_i,
  input  logic     clr_i,
  input  reg_idx_t clr_rd_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  input  reg_idx_t rd_i,
  output logic     rs1_pend_o,
  output logic     rs2_pend_o,
  output logic     rd_pend_o,
  output logic     clr_pend_o
);

  logic [31:1] pending;
  logic [31:1] pending_nxt;
  logic [31:0] pend_ext;

  // Bit 0 of the extended view is a constant 0 so any x0 lookup reads as not pending.
  assign pend_ext   = {pending, 1'b0};
  assign rs1_pend_o = pend_ext[rs1_i];
  assign rs2_pend_o = pend_ext[rs2_i];
  assign rd_pend_o  = pend_ext[rd_i];
  assign clr_pend_o = pend_ext[clr_rd_i];

  always_comb begin
    pending_nxt = pending;
    for (int i = 1; i < 32; i++) begin
      if (set_i && (set_rd_i == reg_idx_t'(i))) begin
        pending_nxt[i] = 1'b1;
      end else if (clr_i && (clr_rd_i == reg_idx_t'(i))) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/rv_regfile_sched.sv
// Register-file write-port arbiter and long-op scoreboard: stalls decode on RAW/WAW/capacity
// hazards and merges late long-latency results onto the single write port (pipeline wins).
// Ports: clk_i, rst_i (async active-high), bus (slave modport of rv_regfile_sched_if).
module rv_regfile_sched
  import rv_defs::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  rv_regfile_sched_if.slave bus
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [OUT_W-1:0]  outstanding;
  logic [WAIT_W-1:0] wait_cnt;
  logic              w_hold;
  logic              err;

  logic rs1_pend, rs2_pend, rd_pend, l_pend;
  logic w_active, accept, issue_long, full, stall;
  logic err_set;

  // A pipeline write to x0 is a no-op and does not occupy the port.
  assign w_active   = bus.w_rd_store_i && !is_x0(bus.w_rd_i);
  assign accept     = bus.l_valid_i && !w_active;
  assign issue_long = bus.d_issue_i && bus.d_long_i;
  assign full       = bus.d_long_i && (outstanding == OUT_MAX);
  assign stall      = bus.d_valid_i &&
                      ((bus.d_use_rs1_i && rs1_pend) ||
                       (bus.d_use_rs2_i && rs2_pend) ||
                       rd_pend || full);

  rv_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (issue_long),
    .set_rd_i   (bus.d_rd_i),
    .clr_i      (accept),
    .clr_rd_i   (bus.l_rd_i),
    .rs1_i      (bus.d_rs1_i),
    .rs2_i      (bus.d_rs2_i),
    .rd_i       (bus.d_rd_i),
    .rs1_pend_o (rs1_pend),
    .rs2_pend_o (rs2_pend),
    .rd_pend_o  (rd_pend),
    .clr_pend_o (l_pend)
  );

  // Write-port mux: pipeline first, then an accepted late result; x0 never strobes.
  always_comb begin
    bus.rf_rd_o       = REG_X0;
    bus.rf_rd_value_o = '0;
    bus.rf_rd_store_o = 1'b0;
    if (w_active) begin
      bus.rf_rd_o       = bus.w_rd_i;
      bus.rf_rd_value_o = bus.w_rd_value_i;
      bus.rf_rd_store_o = 1'b1;
    end else if (accept && !is_x0(bus.l_rd_i)) begin
      bus.rf_rd_o       = bus.l_rd_i;
      bus.rf_rd_value_o = bus.l_value_i;
      bus.rf_rd_store_o = 1'b1;
    end
  end

  assign err_set = (w_hold && w_active) ||
                   (accept && (outstanding == '0)) ||
                   (accept && !is_x0(bus.l_rd_i) && !l_pend) ||
                   (bus.d_issue_i && stall);

  // Counter saturates at both ends so an illegal issue/accept only raises err.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else if (issue_long && !accept) begin
      if (outstanding != OUT_MAX) outstanding <= outstanding + 1'b1;
    end else if (accept && !issue_long) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!bus.l_valid_i || accept) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Hold is released by the accept it forces; the accept takes priority over a re-set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_hold <= 1'b0;
    end else if (accept) begin
      w_hold <= 1'b0;
    end else if (wait_cnt == WAIT_MAX) begin
      w_hold <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign bus.d_stall_o = stall;
  assign bus.l_ready_o = accept;
  assign bus.w_hold_o  = w_hold;
  assign bus.err_o     = err;
  assign bus.busy_o    = (outstanding != '0);

endmodule

// File: tb/tb_rv_regfile_sched.sv
module tb_rv_regfile_sched;
  import rv_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_regfile_sched_if bus ();

  rv_regfile_sched #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.d_valid_i = 0; bus.d_rs1_i = 0; bus.d_rs2_i = 0; bus.d_rd_i = 0;
    bus.d_use_rs1_i = 0; bus.d_use_rs2_i = 0; bus.d_long_i = 0; bus.d_issue_i = 0;
    bus.w_rd_i = 0; bus.w_rd_value_i = 0; bus.w_rd_store_i = 0;
    bus.l_valid_i = 0; bus.l_rd_i = 0; bus.l_value_i = 0;
  endtask

  task automatic decode(input logic issue, input logic lng, input reg_idx_t rd,
                        input logic u1, input reg_idx_t rs1, input logic u2, input reg_idx_t rs2);
    bus.d_valid_i = 1; bus.d_issue_i = issue; bus.d_long_i = lng; bus.d_rd_i = rd;
    bus.d_use_rs1_i = u1; bus.d_rs1_i = rs1; bus.d_use_rs2_i = u2; bus.d_rs2_i = rs2;
  endtask

  task automatic test_reset();
    idle();
    bus.d_valid_i = 1; bus.d_use_rs1_i = 1; bus.d_rs1_i = 5'd3; bus.d_long_i = 1;
    rst = 1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.w_hold_o !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", bus.w_hold_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_o); end
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.d_stall_o); end
    step(); step();
    #2 rst = 0;
    idle();
    step();
  endtask

  task automatic test_load_use();
    decode(1, 1, 5'd5, 0, 0, 0, 0);
    #1;
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL lu_issue_stall got %b want 0", bus.d_stall_o); end
    step();
    decode(0, 0, 5'd6, 1, 5'd5, 1, 5'd1);
    #1;
    checks++; if (bus.d_stall_o !== 1'b1) begin errors++; $display("FAIL lu_raw_stall got %b want 1", bus.d_stall_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL lu_busy got %b want 1", bus.busy_o); end
    bus.l_valid_i = 1; bus.l_rd_i = 5'd5; bus.l_value_i = 32'h1234;
    #1;
    checks++; if (bus.rf_rd_o !== 5'd5) begin errors++; $display("FAIL lu_rf_rd got %0d want 5", bus.rf_rd_o); end
    checks++; if (bus.rf_rd_value_o !== 32'h1234) begin errors++; $display("FAIL lu_rf_val got %h want 00001234", bus.rf_rd_value_o); end
    checks++; if (bus.rf_rd_store_o !== 1'b1) begin errors++; $display("FAIL lu_rf_store got %b want 1", bus.rf_rd_store_o); end
    checks++; if (bus.d_stall_o !== 1'b1) begin errors++; $display("FAIL lu_same_cycle_stall got %b want 1", bus.d_stall_o); end
    step();
    bus.l_valid_i = 0;
    #1;
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL lu_unstall got %b want 0", bus.d_stall_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL lu_idle_busy got %b want 0", bus.busy_o); end
    idle();
  endtask

  task automatic test_contention();
    decode(1, 1, 5'd5, 0, 0, 0, 0);
    step();
    idle();
    bus.w_rd_store_i = 1; bus.w_rd_i = 5'd7; bus.w_rd_value_i = 32'hAAAA_0007;
    bus.l_valid_i = 1; bus.l_rd_i = 5'd5; bus.l_value_i = 32'h5555_0005;
    #1;
    checks++; if (bus.rf_rd_o !== 5'd7) begin errors++; $display("FAIL ct_rf_rd_pipe got %0d want 7", bus.rf_rd_o); end
    checks++; if (bus.rf_rd_value_o !== 32'hAAAA_0007) begin errors++; $display("FAIL ct_rf_val_pipe got %h want aaaa0007", bus.rf_rd_value_o); end
    checks++; if (bus.l_ready_o !== 1'b0) begin errors++; $display("FAIL ct_ready_blocked got %b want 0", bus.l_ready_o); end
    step();
    bus.w_rd_store_i = 0;
    #1;
    checks++; if (bus.rf_rd_o !== 5'd5) begin errors++; $display("FAIL ct_rf_rd_long got %0d want 5", bus.rf_rd_o); end
    checks++; if (bus.rf_rd_value_o !== 32'h5555_0005) begin errors++; $display("FAIL ct_rf_val_long got %h want 55550005", bus.rf_rd_value_o); end
    checks++; if (bus.l_ready_o !== 1'b1) begin errors++; $display("FAIL ct_ready got %b want 1", bus.l_ready_o); end
    step();
    idle();
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ct_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      decode(1, 1, reg_idx_t'(r), 0, 0, 0, 0);
      #1;
      checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL cap_fill_stall_%0d got %b want 0", r, bus.d_stall_o); end
      step();
    end
    decode(0, 1, 5'd10, 0, 0, 0, 0);
    #1;
    checks++; if (bus.d_stall_o !== 1'b1) begin errors++; $display("FAIL cap_full_stall got %b want 1", bus.d_stall_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL cap_busy got %b want 1", bus.busy_o); end
    bus.l_valid_i = 1; bus.l_rd_i = 5'd1; bus.l_value_i = 32'h11;
    step();
    bus.l_valid_i = 0;
    #1;
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL cap_after_accept_stall got %b want 0", bus.d_stall_o); end
    bus.d_valid_i = 0;
    for (int r = 2; r <= 4; r++) begin
      bus.l_valid_i = 1; bus.l_rd_i = reg_idx_t'(r);
      step();
    end
    idle();
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL cap_drain_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL cap_err got %b want 0", bus.err_o); end
  endtask

  task automatic test_starvation();
    decode(1, 1, 5'd8, 0, 0, 0, 0);
    step();
    idle();
    bus.l_valid_i = 1; bus.l_rd_i = 5'd8; bus.l_value_i = 32'h88;
    bus.w_rd_store_i = 1; bus.w_rd_i = 5'd7; bus.w_rd_value_i = 32'h77;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) begin
        checks++; if (bus.w_hold_o !== 1'b0) begin errors++; $display("FAIL st_hold_early got %b want 0", bus.w_hold_o); end
      end
    end
    checks++; if (bus.w_hold_o !== 1'b1) begin errors++; $display("FAIL st_hold_set got %b want 1", bus.w_hold_o); end
    checks++; if (bus.l_ready_o !== 1'b0) begin errors++; $display("FAIL st_starved_ready got %b want 0", bus.l_ready_o); end
    bus.w_rd_store_i = 0;
    #1;
    checks++; if (bus.l_ready_o !== 1'b1) begin errors++; $display("FAIL st_accept got %b want 1", bus.l_ready_o); end
    step();
    idle();
    #1;
    checks++; if (bus.w_hold_o !== 1'b0) begin errors++; $display("FAIL st_hold_clear got %b want 0", bus.w_hold_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL st_err got %b want 0", bus.err_o); end
  endtask

  task automatic test_x0_err();
    decode(1, 1, 5'd0, 0, 0, 0, 0);
    step();
    decode(0, 0, 5'd2, 1, 5'd0, 0, 0);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL x0_busy got %b want 1", bus.busy_o); end
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL x0_no_pending got %b want 0", bus.d_stall_o); end
    idle();
    bus.l_valid_i = 1; bus.l_rd_i = 5'd0; bus.l_value_i = 32'hDEAD;
    #1;
    checks++; if (bus.rf_rd_store_o !== 1'b0) begin errors++; $display("FAIL x0_rf_store got %b want 0", bus.rf_rd_store_o); end
    checks++; if (bus.l_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", bus.l_ready_o); end
    step();
    bus.l_valid_i = 0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL x0_outstanding got %b want 0", bus.busy_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL x0_err got %b want 0", bus.err_o); end
    bus.l_valid_i = 1; bus.l_rd_i = 5'd9; bus.l_value_i = 32'h99;
    step();
    idle();
    #1;
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_unpending got %b want 1", bus.err_o); end
  endtask

  task automatic test_reset_midflight();
    #2 rst = 1;
    #2 rst = 0;
    #1;
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rm_err_cleared got %b want 0", bus.err_o); end
    step();
    decode(1, 1, 5'd3, 0, 0, 0, 0);
    step();
    decode(0, 0, 5'd4, 1, 5'd3, 0, 0);
    #1;
    checks++; if (bus.d_stall_o !== 1'b1) begin errors++; $display("FAIL rm_pre_stall got %b want 1", bus.d_stall_o); end
    #2 rst = 1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL rm_stall_in_reset got %b want 0", bus.d_stall_o); end
    rst = 0;
    step();
    checks++; if (bus.d_stall_o !== 1'b0) begin errors++; $display("FAIL rm_post_stall got %b want 0", bus.d_stall_o); end
    idle();
  endtask

  task automatic test_issue_while_stalled();
    decode(1, 1, 5'd3, 0, 0, 0, 0);
    step();
    decode(1, 0, 5'd4, 1, 5'd3, 0, 0);
    #1;
    checks++; if (bus.d_stall_o !== 1'b1) begin errors++; $display("FAIL ws_stall got %b want 1", bus.d_stall_o); end
    step();
    idle();
    #1;
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ws_err got %b want 1", bus.err_o); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_contention();
    test_capacity();
    test_starvation();
    test_x0_err();
    test_reset_midflight();
    test_issue_while_stalled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
